// File: rtl/mem_rmw_pkg.sv
// -----------------------------------------------------------------------------
// mem_rmw_pkg
// Shared definitions for the data-memory read-modify-write sequencer:
//   - access size encodings as driven by the load/store stage
//   - FSM state encoding
//   - access latencies, counted from the acceptance edge to the done cycle
//   - the alignment rule applied when a request is accepted
// -----------------------------------------------------------------------------
package mem_rmw_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_RESP
    } state_t;

    localparam int LAT_ERR     = 1;
    localparam int LAT_WORD_ST = 2;
    localparam int LAT_LOAD    = 3;
    localparam int LAT_SUBW_ST = 4;

    // Reserved size, odd halfword address or non-word-aligned word address.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        return (size == SZ_RSVD) ||
               (size == SZ_HALF && offset[0]) ||
               (size == SZ_WORD && offset != 2'b00);
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// -----------------------------------------------------------------------------
// byte_lane_unit
// Purely combinational big-endian lane logic (byte offset 0 = bits [31:24]).
// Ports:
//   i_word     - word read from RAM
//   i_offset   - byte offset within the word (addr[1:0])
//   i_size     - SZ_BYTE / SZ_HALF / SZ_WORD
//   i_sext     - sign-extend the extracted load value
//   i_st_data  - right-justified store data (byte uses [7:0], half [15:0])
//   o_merged   - i_word with the store data inserted in the addressed lane
//   o_load     - addressed lane, right-justified and extended
// -----------------------------------------------------------------------------
module byte_lane_unit
    import mem_rmw_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [15:0] i_st_data,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    // Right-shift that brings the addressed lane down to bit 0:
    // byte offset o sits 8*(3-o) bits up, and ~o equals 3-o for two bits.
    logic [4:0]  w_sh_byte;
    logic [4:0]  w_sh_half;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_sh_byte = {~i_offset, 3'b000};
    assign w_sh_half = {~i_offset[1], 4'b0000};
    assign w_byte    = 8'(i_word >> w_sh_byte);
    assign w_half    = 16'(i_word >> w_sh_half);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        o_merged = i_word;
        o_load   = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_merged = (i_word & ~(32'h0000_00FF << w_sh_byte)) |
                           ({24'h0, i_st_data[7:0]} << w_sh_byte);
                o_load   = i_sext ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            end
            SZ_HALF: begin
                o_merged = (i_word & ~(32'h0000_FFFF << w_sh_half)) |
                           ({16'h0, i_st_data} << w_sh_half);
                o_load   = i_sext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// mem_rmw_ctrl
// Sequences MIPS32 loads/stores onto a word-wide synchronous RAM without byte
// enables. Sub-word stores are done as read-modify-write; the core is stalled
// through o_busy until the one-cycle o_done pulse.
// Ports:
//   i_clk, i_rst_n      - clock (rising edge), asynchronous active-low reset
//   i_req               - access request, held until o_done
//   i_we, i_size, i_sext, i_addr, i_wdata - access attributes (latched on accept)
//   o_rdata             - load result, held until the next successful load
//   o_busy              - stall to the core (i_req & ~o_done)
//   o_done, o_align_err - completion pulse and coincident misalignment flag
//   o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wdata, i_mem_rdata - RAM interface
// -----------------------------------------------------------------------------
module mem_rmw_ctrl
    import mem_rmw_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_sext,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_align_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    state_t            r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [1:0]        r_off;
    logic [15:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_align_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [31:0]       r_mem_wdata;

    logic [31:0]       w_merged;
    logic [31:0]       w_load;
    logic              w_misaligned;

    // Address bits above the RAM word address alias and are not decoded.
    logic              w_unused_addr;
    assign w_unused_addr = ^i_addr[31:ADDR_W+2];

    assign w_misaligned = is_misaligned(i_size, i_addr[1:0]);

    // RAM read data is valid in MERGE, which is the only state that uses
    // these outputs.
    byte_lane_unit u_lane (
        .i_word    (i_mem_rdata),
        .i_offset  (r_off),
        .i_size    (r_size),
        .i_sext    (r_sext),
        .i_st_data (r_wdata),
        .o_merged  (w_merged),
        .o_load    (w_load)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_sext      <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register sees the pre-edge values; the defaults below make the
            // pulse outputs last one cycle unless a branch re-asserts them.
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_we       <= i_we;
                        r_size     <= i_size;
                        r_sext     <= i_sext;
                        r_off      <= i_addr[1:0];
                        r_wdata    <= i_wdata[15:0];
                        r_mem_addr <= i_addr[ADDR_W+1:2];
                        if (w_misaligned) begin
                            r_done      <= 1'b1;
                            r_align_err <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (i_we && i_size == SZ_WORD) begin
                            r_mem_wr    <= 1'b1;
                            r_mem_wdata <= i_wdata;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_mem_rd <= 1'b1;
                            r_state  <= ST_READ;
                        end
                    end
                end
                ST_READ: r_state <= ST_MERGE;
                ST_MERGE: begin
                    if (r_we) begin
                        r_mem_wdata <= w_merged;
                        r_mem_wr    <= 1'b1;
                        r_state     <= ST_WRITE;
                    end else begin
                        r_rdata <= w_load;
                        r_done  <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rdata     = r_rdata;
    assign o_done      = r_done;
    assign o_align_err = r_align_err;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = i_req & ~r_done;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_rmw_ctrl
// Drives mem_rmw_ctrl against a synchronous word RAM and compares every access
// with a byte-array reference model of memory and the load result register.
// -----------------------------------------------------------------------------
module tb_mem_rmw_ctrl;
    import mem_rmw_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BUDGET = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req, we, sext;
    logic [1:0]        size;
    logic [31:0]       addr, wdata;
    logic [31:0]       rdata;
    logic              busy, done, align_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd, mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] ram       [DEPTH];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_size      (size),
        .i_sext      (sext),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_align_err (align_err),
        .o_mem_addr  (mem_addr),
        .o_mem_rd    (mem_rd),
        .o_mem_wr    (mem_wr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Synchronous RAM: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Big-endian view of a word as four bytes: byte 0 is the most significant.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input int o);
        return 8'((w >> (8 * (3 - o))) & 32'hFF);
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input int o, input logic [7:0] b);
        logic [7:0] bytes [4];
        for (int i = 0; i < 4; i++) bytes[i] = get_byte(w, i);
        bytes[o] = b;
        return {bytes[0], bytes[1], bytes[2], bytes[3]};
    endfunction

    task automatic do_access(input logic a_we, input logic [1:0] a_size, input logic a_sext,
                             input logic [31:0] a_addr, input logic [31:0] a_wdata);
        int          o, widx, lat, exp_lat, nrd, nwr, both;
        logic        err, got, aerr;
        logic [31:0] w, exp_wdata;
        logic [7:0]  b0, b1;
        o    = int'(a_addr[1:0]);
        widx = int'(a_addr[ADDR_W+1:2]);
        err  = (a_size == 2'b11) || (a_size == 2'b01 && o % 2 != 0) ||
               (a_size == 2'b10 && o != 0);
        w    = model_mem[widx];
        if (err) exp_lat = LAT_ERR;
        else if (a_we) exp_lat = (a_size == 2'b10) ? LAT_WORD_ST : LAT_SUBW_ST;
        else exp_lat = LAT_LOAD;

        if (!err && a_we) begin
            if (a_size == 2'b10) w = a_wdata;
            else if (a_size == 2'b00) w = put_byte(w, o, a_wdata[7:0]);
            else w = put_byte(put_byte(w, o, a_wdata[15:8]), o + 1, a_wdata[7:0]);
            model_mem[widx] = w;
        end else if (!err) begin
            b0 = get_byte(w, o);
            b1 = get_byte(w, o + 1);
            if (a_size == 2'b10) model_rdata = w;
            else if (a_size == 2'b00)
                model_rdata = (a_sext && b0[7]) ? {24'hFFFFFF, b0} : {24'h0, b0};
            else
                model_rdata = (a_sext && b0[7]) ? {16'hFFFF, b0, b1} : {16'h0, b0, b1};
        end
        exp_wdata = w;

        @(negedge clk);
        req = 1'b1; we = a_we; size = a_size; sext = a_sext; addr = a_addr; wdata = a_wdata;
        @(posedge clk);
        lat = 0; got = 1'b0; aerr = 1'b0; nrd = 0; nwr = 0; both = 0;
        while (!got && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (mem_rd) begin
                nrd++;
                check("rd_addr", 32'(mem_addr), 32'(widx));
            end
            if (mem_wr) begin
                nwr++;
                check("wr_addr", 32'(mem_addr), 32'(widx));
                check("wr_data", mem_wdata, exp_wdata);
            end
            if (mem_rd && mem_wr) both++;
            if (done) begin
                got  = 1'b1;
                aerr = align_err;
            end else begin
                check("busy_stall", 32'(busy), 32'd1);
                @(posedge clk);
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("align_err", 32'(aerr), 32'(err));
        check("rd_count", 32'(nrd), (err || (a_we && a_size == 2'b10)) ? 32'd0 : 32'd1);
        check("wr_count", 32'(nwr), (err || !a_we) ? 32'd0 : 32'd1);
        check("rd_wr_overlap", 32'(both), 32'd0);

        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("rdata", rdata, model_rdata);
        check("ram_word", ram[widx], model_mem[widx]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_align"}, 32'(align_err), 32'h0);
        check({tag, "_rd"}, 32'(mem_rd), 32'h0);
        check({tag, "_wr"}, 32'(mem_wr), 32'h0);
        check({tag, "_maddr"}, 32'(mem_addr), 32'h0);
        check({tag, "_mwdata"}, mem_wdata, 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int wr_seen;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]       = 32'h0;
            model_mem[i] = 32'h0;
        end
        model_rdata = 32'h0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Byte stores build word 0 one lane at a time.
        do_access(1'b1, SZ_BYTE, 1'b0, 32'd0, 32'h0000_00AA);
        check("sb0_word", ram[0], 32'hAA00_0000);
        do_access(1'b1, SZ_BYTE, 1'b0, 32'd1, 32'h0000_00BB);
        check("sb1_word", ram[0], 32'hAABB_0000);
        do_access(1'b1, SZ_BYTE, 1'b0, 32'd2, 32'h0000_00CC);
        check("sb2_word", ram[0], 32'hAABB_CC00);
        do_access(1'b1, SZ_BYTE, 1'b0, 32'd3, 32'h0000_00DD);
        check("sb3_word", ram[0], 32'hAABB_CCDD);

        // Loads of every size and extension.
        do_access(1'b0, SZ_BYTE, 1'b1, 32'd1, 32'h0);
        check("lb1", rdata, 32'hFFFF_FFBB);
        do_access(1'b0, SZ_BYTE, 1'b0, 32'd1, 32'h0);
        check("lbu1", rdata, 32'h0000_00BB);
        do_access(1'b0, SZ_WORD, 1'b1, 32'd0, 32'h0);
        check("lw0", rdata, 32'hAABB_CCDD);

        // Halfword store and loads.
        do_access(1'b1, SZ_HALF, 1'b0, 32'd2, 32'h0000_1234);
        check("sh2_word", ram[0], 32'hAABB_1234);
        do_access(1'b0, SZ_HALF, 1'b1, 32'd2, 32'h0);
        check("lh2", rdata, 32'h0000_1234);
        do_access(1'b0, SZ_HALF, 1'b1, 32'd0, 32'h0);
        check("lh0", rdata, 32'hFFFF_AABB);

        // Misaligned accesses leave rdata and RAM untouched.
        do_access(1'b0, SZ_WORD, 1'b0, 32'd2, 32'h0);
        check("lw2_rdata_kept", rdata, 32'hFFFF_AABB);
        do_access(1'b1, SZ_HALF, 1'b0, 32'd1, 32'h0000_5A5A);
        check("sh1_ram_kept", ram[0], 32'hAABB_1234);
        do_access(1'b0, SZ_RSVD, 1'b0, 32'd0, 32'h0);

        // Word store.
        do_access(1'b1, SZ_WORD, 1'b0, 32'd4, 32'h5566_7788);
        check("sw4_word", ram[1], 32'h5566_7788);

        // Reset during MERGE of a byte store aborts it before the write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = SZ_BYTE; sext = 1'b0; addr = 32'd4; wdata = 32'h11;
        @(posedge clk);            // acceptance -> READ
        @(posedge clk);            // READ -> MERGE
        #2 rst_n = 1'b0; req = 1'b0;
        #1 check_all_zero("midreset");
        model_rdata = 32'h0;
        wr_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
        end
        check("midreset_no_write", 32'(wr_seen), 32'd0);
        check("midreset_word1", ram[1], 32'h5566_7788);
        do_access(1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0);
        check("lw4_after_reset", rdata, 32'h5566_7788);

        // Random mix over a small address window, including misaligned
        // and reserved-size requests.
        for (int i = 0; i < 80; i++) begin
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
